// File: rtl/pll_lvds_phase_ctrl.sv
// pll_lvds_phase_ctrl
//   Clock-management controller for the LVDS PLL, clocked from the PLL
//   reference clock. Filters the raw lock indication, sequences the LVDS
//   reset, counts lock-loss events and drives the PLL dynamic phase-shift
//   port (phase_en / updn / cntsel with the active-low phase_done handshake).
//
// Ports
//   refclk        : sole clock
//   rst           : synchronous active-high reset
//   pll_locked    : raw PLL lock (asynchronous, synchronised here)
//   phase_done    : PLL phase-step done, active low (asynchronous, synchronised here)
//   step_req      : phase-step request, honoured only when idle
//   step_sel      : target output counter (must be < NUM_CLKS)
//   step_dir      : 1 = advance (updn high), 0 = retard
//   step_cnt      : number of steps to perform
//   phase_en      : phase-step enable to PLL
//   updn          : step direction to PLL
//   cntsel        : counter select to PLL
//   step_busy     : request in progress
//   step_done     : one-cycle pulse, all steps completed
//   step_err      : one-cycle pulse, timeout / lock loss / bad select
//   locked_filt   : filtered lock
//   lvds_rst      : active-high reset for LVDS logic
//   lock_loss_cnt : saturating count of locked_filt falling edges

module pll_lvds_phase_ctrl #(
    parameter int NUM_CLKS     = 4,
    parameter int CNTSEL_W     = 5,
    parameter int LOCK_FILT    = 256,
    parameter int PHASE_EN_CYC = 2,
    parameter int STEP_TIMEOUT = 1023
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                phase_done,
    input  logic                step_req,
    input  logic [CNTSEL_W-1:0] step_sel,
    input  logic                step_dir,
    input  logic [7:0]          step_cnt,
    output logic                phase_en,
    output logic                updn,
    output logic [CNTSEL_W-1:0] cntsel,
    output logic                step_busy,
    output logic                step_done,
    output logic                step_err,
    output logic                locked_filt,
    output logic                lvds_rst,
    output logic [7:0]          lock_loss_cnt
);

    localparam int LF_W  = $clog2(LOCK_FILT + 1);
    localparam int TMO_W = $clog2(STEP_TIMEOUT + 1);
    localparam int PEN_W = $clog2(PHASE_EN_CYC + 1);

    // The filter declares lock on the same edge its counter reaches LOCK_FILT.
    localparam logic [LF_W-1:0]     LF_LAST      = LF_W'(LOCK_FILT - 1);
    localparam logic [LF_W-1:0]     LF_MAX       = LF_W'(LOCK_FILT);
    localparam logic [TMO_W-1:0]    TMO_LAST     = TMO_W'(STEP_TIMEOUT - 1);
    localparam logic [PEN_W-1:0]    PEN_LAST     = PEN_W'(PHASE_EN_CYC - 1);
    localparam logic [CNTSEL_W:0]   NUM_CLKS_EXT = (CNTSEL_W + 1)'(NUM_CLKS);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_LO   = 3'd3,
        ST_WAIT_HI   = 3'd4
    } state_t;

    // Range check of a requested counter select against the PLL's counters.
    function automatic logic sel_valid(input logic [CNTSEL_W-1:0] sel);
        return ({1'b0, sel} < NUM_CLKS_EXT);
    endfunction

    // Synchronisers
    logic lock_meta_r;
    logic lock_sync_r;
    logic done_meta_r;
    logic done_sync_r;

    // Lock filter / reset sequencing
    logic [LF_W-1:0] lf_cnt_r;
    logic            locked_filt_r;
    logic            lvds_rst_r;
    logic [7:0]      lock_loss_cnt_r;
    logic            lock_fall_s;

    // Step engine
    state_t                state_r;
    state_t                state_nxt_s;
    logic                  phase_en_r;
    logic                  phase_en_nxt_s;
    logic                  updn_r;
    logic                  updn_nxt_s;
    logic [CNTSEL_W-1:0]   cntsel_r;
    logic [CNTSEL_W-1:0]   cntsel_nxt_s;
    logic                  busy_r;
    logic                  busy_nxt_s;
    logic                  step_done_r;
    logic                  step_done_nxt_s;
    logic                  step_err_r;
    logic                  step_err_nxt_s;
    logic [7:0]            rem_r;
    logic [7:0]            rem_nxt_s;
    logic [PEN_W-1:0]      pen_cnt_r;
    logic [PEN_W-1:0]      pen_cnt_nxt_s;
    logic [TMO_W-1:0]      tmo_cnt_r;
    logic [TMO_W-1:0]      tmo_cnt_nxt_s;
    logic                  gap_r;
    logic                  gap_nxt_s;

    logic accept_s;
    logic sel_ok_s;
    logic tmo_hit_s;
    logic pen_last_s;

    // Two-flop synchronisers for the asynchronous PLL status inputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            done_meta_r <= 1'b0;
            done_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
            done_meta_r <= phase_done;
            done_sync_r <= done_meta_r;
        end
    end

    // locked_filt is about to drop: it is set and synchronised lock reads 0.
    assign lock_fall_s = locked_filt_r & ~lock_sync_r;

    // Lock filter, LVDS reset and lock-loss counter.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lf_cnt_r        <= {LF_W{1'b0}};
            locked_filt_r   <= 1'b0;
            lvds_rst_r      <= 1'b1;
            lock_loss_cnt_r <= 8'd0;
        end else begin
            if (!lock_sync_r) begin
                lf_cnt_r <= {LF_W{1'b0}};
            end else if (lf_cnt_r != LF_MAX) begin
                lf_cnt_r <= lf_cnt_r + LF_W'(1);
            end else begin
                lf_cnt_r <= lf_cnt_r;
            end

            if (!lock_sync_r) begin
                locked_filt_r <= 1'b0;
            end else if (lf_cnt_r >= LF_LAST) begin
                locked_filt_r <= 1'b1;
            end else begin
                locked_filt_r <= locked_filt_r;
            end

            lvds_rst_r <= ~locked_filt_r;

            if (lock_fall_s && (lock_loss_cnt_r != 8'hFF)) begin
                lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
            end else begin
                lock_loss_cnt_r <= lock_loss_cnt_r;
            end
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && !busy_r && step_req;
    assign sel_ok_s   = sel_valid(step_sel);
    assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    assign pen_last_s = (pen_cnt_r == PEN_LAST);

    // FSM state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r <= ST_WAIT_LOCK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; lock loss overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        if (lock_fall_s) begin
            state_nxt_s = ST_WAIT_LOCK;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (locked_filt_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_IDLE: begin
                    if (accept_s && sel_ok_s && (step_cnt != 8'd0)) begin
                        state_nxt_s = ST_PULSE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (pen_last_s) begin
                        state_nxt_s = ST_WAIT_LO;
                    end else begin
                        state_nxt_s = ST_PULSE;
                    end
                end
                ST_WAIT_LO: begin
                    if (tmo_hit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!done_sync_r) begin
                        state_nxt_s = ST_WAIT_HI;
                    end else begin
                        state_nxt_s = ST_WAIT_LO;
                    end
                end
                ST_WAIT_HI: begin
                    // gap_r marks the single idle cycle between steps.
                    if (tmo_hit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (gap_r) begin
                        state_nxt_s = ST_PULSE;
                    end else if (done_sync_r && (rem_r == 8'd1)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_HI;
                    end
                end
                default: begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    // FSM output logic: next values of the registered outputs and step datapath.
    always_comb begin
        phase_en_nxt_s  = 1'b0;
        step_done_nxt_s = 1'b0;
        step_err_nxt_s  = 1'b0;
        busy_nxt_s      = busy_r;
        updn_nxt_s      = updn_r;
        cntsel_nxt_s    = cntsel_r;
        rem_nxt_s       = rem_r;
        pen_cnt_nxt_s   = pen_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        gap_nxt_s       = 1'b0;
        if (lock_fall_s) begin
            // phase_en is already defaulted low; abort any step in flight.
            step_err_nxt_s = busy_r;
            busy_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (busy_r) begin
                        // Zero-count request accepted last cycle.
                        step_done_nxt_s = 1'b1;
                        busy_nxt_s      = 1'b0;
                    end else if (accept_s && !sel_ok_s) begin
                        step_err_nxt_s = 1'b1;
                        busy_nxt_s     = 1'b0;
                    end else if (accept_s) begin
                        cntsel_nxt_s  = step_sel;
                        updn_nxt_s    = step_dir;
                        rem_nxt_s     = step_cnt;
                        busy_nxt_s    = 1'b1;
                        pen_cnt_nxt_s = {PEN_W{1'b0}};
                    end else begin
                        busy_nxt_s = 1'b0;
                    end
                end
                ST_PULSE: begin
                    phase_en_nxt_s = 1'b1;
                    pen_cnt_nxt_s  = pen_cnt_r + PEN_W'(1);
                    if (pen_last_s) begin
                        tmo_cnt_nxt_s = {TMO_W{1'b0}};
                    end else begin
                        tmo_cnt_nxt_s = tmo_cnt_r;
                    end
                end
                ST_WAIT_LO: begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    if (tmo_hit_s) begin
                        step_err_nxt_s = 1'b1;
                        busy_nxt_s     = 1'b0;
                    end else begin
                        busy_nxt_s = busy_r;
                    end
                end
                ST_WAIT_HI: begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    if (tmo_hit_s) begin
                        step_err_nxt_s = 1'b1;
                        busy_nxt_s     = 1'b0;
                    end else if (gap_r) begin
                        pen_cnt_nxt_s = {PEN_W{1'b0}};
                    end else if (done_sync_r) begin
                        rem_nxt_s = rem_r - 8'd1;
                        if (rem_r == 8'd1) begin
                            step_done_nxt_s = 1'b1;
                            busy_nxt_s      = 1'b0;
                        end else begin
                            gap_nxt_s = 1'b1;
                        end
                    end else begin
                        busy_nxt_s = busy_r;
                    end
                end
                ST_WAIT_LOCK: begin
                    busy_nxt_s = 1'b0;
                end
                default: begin
                    busy_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs and step datapath.
    always_ff @(posedge refclk) begin
        if (rst) begin
            phase_en_r  <= 1'b0;
            updn_r      <= 1'b0;
            cntsel_r    <= {CNTSEL_W{1'b0}};
            busy_r      <= 1'b0;
            step_done_r <= 1'b0;
            step_err_r  <= 1'b0;
            rem_r       <= 8'd0;
            pen_cnt_r   <= {PEN_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            gap_r       <= 1'b0;
        end else begin
            phase_en_r  <= phase_en_nxt_s;
            updn_r      <= updn_nxt_s;
            cntsel_r    <= cntsel_nxt_s;
            busy_r      <= busy_nxt_s;
            step_done_r <= step_done_nxt_s;
            step_err_r  <= step_err_nxt_s;
            rem_r       <= rem_nxt_s;
            pen_cnt_r   <= pen_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            gap_r       <= gap_nxt_s;
        end
    end

    assign phase_en      = phase_en_r;
    assign updn          = updn_r;
    assign cntsel        = cntsel_r;
    assign step_busy     = busy_r;
    assign step_done     = step_done_r;
    assign step_err      = step_err_r;
    assign locked_filt   = locked_filt_r;
    assign lvds_rst      = lvds_rst_r;
    assign lock_loss_cnt = lock_loss_cnt_r;

endmodule

// File: tb/tb_pll_lvds_phase_ctrl.sv
// Directed bench for pll_lvds_phase_ctrl. Inputs are driven and outputs
// sampled on the falling edge of refclk; "after edge k" below means the
// falling edge following rising edge k.

module tb_pll_lvds_phase_ctrl;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       phase_done;
    logic       step_req;
    logic [4:0] step_sel;
    logic       step_dir;
    logic [7:0] step_cnt;
    logic       phase_en;
    logic       updn;
    logic [4:0] cntsel;
    logic       step_busy;
    logic       step_done;
    logic       step_err;
    logic       locked_filt;
    logic       lvds_rst;
    logic [7:0] lock_loss_cnt;

    int passed;
    int total;
    int fails;

    pll_lvds_phase_ctrl #(
        .NUM_CLKS     (4),
        .CNTSEL_W     (5),
        .LOCK_FILT    (16),
        .PHASE_EN_CYC (2),
        .STEP_TIMEOUT (20)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .phase_done    (phase_done),
        .step_req      (step_req),
        .step_sel      (step_sel),
        .step_dir      (step_dir),
        .step_cnt      (step_cnt),
        .phase_en      (phase_en),
        .updn          (updn),
        .cntsel        (cntsel),
        .step_busy     (step_busy),
        .step_done     (step_done),
        .step_err      (step_err),
        .locked_filt   (locked_filt),
        .lvds_rst      (lvds_rst),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Reference clock, 10 time units period.
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // PLL phase-step model: phase_done low 3 cycles after a phase_en rise,
    // back high 5 cycles later. Disabled when model_respond is 0.
    logic model_respond;
    logic pen_prev;
    int   lo_cd;
    int   hi_cd;
    initial begin
        phase_done    = 1'b1;
        model_respond = 1'b1;
        pen_prev      = 1'b0;
        lo_cd         = 0;
        hi_cd         = 0;
    end
    always @(negedge refclk) begin
        if (model_respond && phase_en && !pen_prev) begin
            lo_cd = 3;
        end else if (lo_cd > 0) begin
            lo_cd = lo_cd - 1;
            if (lo_cd == 0) begin
                phase_done = 1'b0;
                hi_cd      = 5;
            end
        end else if (hi_cd > 0) begin
            hi_cd = hi_cd - 1;
            if (hi_cd == 0) phase_done = 1'b1;
        end
        pen_prev = phase_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request at the current falling edge; returns after accept edge.
    task automatic request(input logic [4:0] sel, input logic dir, input logic [7:0] cnt);
        step_sel = sel;
        step_dir = dir;
        step_cnt = cnt;
        step_req = 1'b1;
        @(negedge refclk);
        step_req = 1'b0;
    endtask

    initial begin
        int lf_at;
        int lr_at;
        int pen_hi;
        int rises;
        int bad;
        int busy_low;
        int done_at;
        int done_n;
        int err_at;
        int seen;
        logic prev;

        passed     = 0;
        total      = 0;
        fails      = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        step_req   = 1'b0;
        step_sel   = 5'd0;
        step_dir   = 1'b0;
        step_cnt   = 8'd0;
        repeat (3) @(negedge refclk);

        // Reset state
        chk("rst_phase_en", 32'(phase_en), 32'd0);
        chk("rst_updn", 32'(updn), 32'd0);
        chk("rst_cntsel", 32'(cntsel), 32'd0);
        chk("rst_busy", 32'(step_busy), 32'd0);
        chk("rst_done", 32'(step_done), 32'd0);
        chk("rst_err", 32'(step_err), 32'd0);
        chk("rst_locked_filt", 32'(locked_filt), 32'd0);
        chk("rst_lvds_rst", 32'(lvds_rst), 32'd1);
        chk("rst_llc", 32'(lock_loss_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge refclk);

        // Lock acquisition: locked_filt at 18, lvds_rst falls at 19
        pll_locked = 1'b1;
        lf_at = 0;
        lr_at = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge refclk);
            if (locked_filt && lf_at == 0) lf_at = i;
            if (!lvds_rst && lr_at == 0) lr_at = i;
        end
        chk("lock_rise_cyc", 32'(lf_at), 32'd18);
        chk("lvds_rst_fall_cyc", 32'(lr_at), 32'd19);
        chk("lock_llc0", 32'(lock_loss_cnt), 32'd0);

        // Three advance steps on counter 2; re-request while busy is ignored
        request(5'd2, 1'b1, 8'd3);
        chk("s3_busy_acc", 32'(step_busy), 32'd1);
        chk("s3_pen_acc", 32'(phase_en), 32'd0);
        pen_hi = 0; rises = 0; bad = 0; busy_low = 0; done_at = 0; done_n = 0;
        prev = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin
                step_req = 1'b1;
                step_sel = 5'd1;
                step_dir = 1'b0;
            end
            if (i == 30) step_req = 1'b0;
            @(negedge refclk);
            if (phase_en) pen_hi++;
            if (phase_en && !prev) rises++;
            if (phase_en && (cntsel != 5'd2 || updn != 1'b1)) bad++;
            if (step_done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (!step_busy && i < 38) busy_low++;
            prev = phase_en;
        end
        chk("s3_pulses", 32'(rises), 32'd3);
        chk("s3_pen_cycles", 32'(pen_hi), 32'd6);
        chk("s3_sel_dir_bad", 32'(bad), 32'd0);
        chk("s3_done_cyc", 32'(done_at), 32'd38);
        chk("s3_done_count", 32'(done_n), 32'd1);
        chk("s3_busy_low", 32'(busy_low), 32'd0);
        chk("s3_busy_end", 32'(step_busy), 32'd0);

        // Bad counter select
        request(5'd7, 1'b0, 8'd1);
        chk("bad_err", 32'(step_err), 32'd1);
        chk("bad_busy", 32'(step_busy), 32'd0);
        chk("bad_cntsel_held", 32'(cntsel), 32'd2);
        @(negedge refclk);
        chk("bad_err_pulse", 32'(step_err), 32'd0);
        chk("bad_pen", 32'(phase_en), 32'd0);

        // Zero-count request
        request(5'd0, 1'b0, 8'd0);
        chk("zero_busy", 32'(step_busy), 32'd1);
        chk("zero_done_early", 32'(step_done), 32'd0);
        @(negedge refclk);
        chk("zero_done", 32'(step_done), 32'd1);
        chk("zero_busy_clr", 32'(step_busy), 32'd0);
        chk("zero_pen", 32'(phase_en), 32'd0);
        @(negedge refclk);
        chk("zero_done_pulse", 32'(step_done), 32'd0);

        // Timeout: WAIT_LO entered after edge N+2, error at N+22
        model_respond = 1'b0;
        request(5'd1, 1'b0, 8'd1);
        err_at = 0; pen_hi = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge refclk);
            if (phase_en) pen_hi++;
            if (step_err && err_at == 0) err_at = i;
        end
        chk("tmo_err_cyc", 32'(err_at), 32'd22);
        chk("tmo_pen_cycles", 32'(pen_hi), 32'd2);
        chk("tmo_busy", 32'(step_busy), 32'd0);
        chk("tmo_cntsel", 32'(cntsel), 32'd1);
        chk("tmo_updn", 32'(updn), 32'd0);

        // Accepted again after timeout
        model_respond = 1'b1;
        request(5'd3, 1'b1, 8'd1);
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge refclk);
            if (step_done && done_at == 0) done_at = i;
        end
        chk("post_tmo_done_cyc", 32'(done_at), 32'd12);

        // Lock loss during WAIT_HI: pll_locked drops after N+8, filter falls at N+11
        request(5'd2, 1'b1, 8'd3);
        repeat (8) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        chk("ll_busy_before", 32'(step_busy), 32'd1);
        chk("ll_lf_before", 32'(locked_filt), 32'd1);
        @(negedge refclk);
        chk("ll_pen", 32'(phase_en), 32'd0);
        chk("ll_err", 32'(step_err), 32'd1);
        chk("ll_busy", 32'(step_busy), 32'd0);
        chk("ll_lf", 32'(locked_filt), 32'd0);
        chk("ll_lvds_rst_lag", 32'(lvds_rst), 32'd0);
        @(negedge refclk);
        chk("ll_lvds_rst", 32'(lvds_rst), 32'd1);
        chk("ll_err_pulse", 32'(step_err), 32'd0);
        chk("ll_llc", 32'(lock_loss_cnt), 32'd1);
        repeat (6) @(negedge refclk);

        // Relock with a request held during WAIT_LOCK (must be ignored)
        pll_locked = 1'b1;
        step_req   = 1'b1;
        step_sel   = 5'd0;
        step_cnt   = 8'd0;
        lf_at = 0; seen = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 10) step_req = 1'b0;
            @(negedge refclk);
            if (locked_filt && lf_at == 0) lf_at = i;
            if (step_busy || step_err || step_done) seen++;
        end
        chk("relock_cyc", 32'(lf_at), 32'd18);
        chk("relock_ignored_req", 32'(seen), 32'd0);
        request(5'd0, 1'b0, 8'd0);
        chk("relock_idle_accept", 32'(step_busy), 32'd1);
        repeat (3) @(negedge refclk);

        // Lock-loss counter saturation
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b1;
            repeat (20) @(negedge refclk);
            pll_locked = 1'b0;
            repeat (5) @(negedge refclk);
            if (k == 252) chk("llc_254", 32'(lock_loss_cnt), 32'd254);
        end
        chk("llc_sat", 32'(lock_loss_cnt), 32'd255);

        // Reset during PULSE
        pll_locked = 1'b1;
        repeat (22) @(negedge refclk);
        request(5'd1, 1'b1, 8'd2);
        @(negedge refclk);
        chk("mid_pulse_pen", 32'(phase_en), 32'd1);
        rst = 1'b1;
        @(negedge refclk);
        chk("mrst_phase_en", 32'(phase_en), 32'd0);
        chk("mrst_updn", 32'(updn), 32'd0);
        chk("mrst_cntsel", 32'(cntsel), 32'd0);
        chk("mrst_busy", 32'(step_busy), 32'd0);
        chk("mrst_done", 32'(step_done), 32'd0);
        chk("mrst_err", 32'(step_err), 32'd0);
        chk("mrst_locked_filt", 32'(locked_filt), 32'd0);
        chk("mrst_lvds_rst", 32'(lvds_rst), 32'd1);
        chk("mrst_llc", 32'(lock_loss_cnt), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pll_lvds_phase_ctrl.md
# pll_lvds_phase_ctrl

Parametrised clock-management controller for the LVDS PLL. It filters the PLL lock indication, sequences the LVDS-domain reset, and counts lock-loss events. It also drives the PLL dynamic phase-shift port (phase_en/updn/cntsel, phase_done handshake) so any output counter can be stepped at run time instead of using a fixed compile-time phase. It sits beside the PLL wrapper, clocked from the PLL reference clock.

## Interface
- NUM_CLKS, 4, number of PLL output counters addressable (1..18)
- CNTSEL_W, 5, width of counter-select bus
- LOCK_FILT, 256, consecutive synchronised-lock cycles required before lock is declared (>=2)
- PHASE_EN_CYC, 2, phase_en pulse width in cycles (>=1)
- STEP_TIMEOUT, 1023, max cycles waiting on phase_done per step

- refclk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous; 2-flop synchronised internally
- phase_done  in  1  PLL phase-step done, active-low, asynchronous; 2-flop synchronised internally
- step_req  in  1  request pulse, sampled only in IDLE
- step_sel  in  CNTSEL_W  target counter, must be < NUM_CLKS
- step_dir  in  1  1 = advance (updn high), 0 = retard
- step_cnt  in  8  number of steps, latched on acceptance
- phase_en  out  1  to PLL
- updn  out  1  to PLL
- cntsel  out  CNTSEL_W  to PLL
- step_busy  out  1  high from acceptance until done/err
- step_done  out  1  one-cycle pulse, all steps completed
- step_err  out  1  one-cycle pulse: timeout, lock loss, or bad step_sel
- locked_filt  out  1  filtered lock
- lvds_rst  out  1  active-high reset for LVDS logic
- lock_loss_cnt  out  8  saturating count of locked_filt falling edges

## Operation
- Reset values: phase_en 0, updn 0, cntsel 0, step_busy 0, step_done 0, step_err 0, locked_filt 0, lvds_rst 1, lock_loss_cnt 0, state WAIT_LOCK, both synchronisers 0.
- Lock filter: counter increments while synchronised lock is 1 and clears to 0 when it is 0. locked_filt sets when the count reaches LOCK_FILT. It clears on the cycle after the synchronised lock reads 0.
- lvds_rst is a registered copy of !locked_filt.
- lock_loss_cnt increments on each 1->0 transition of locked_filt and saturates at 255.
- FSM states: WAIT_LOCK, IDLE, PULSE, WAIT_LO, WAIT_HI.
  - WAIT_LOCK -> IDLE when locked_filt = 1.
  - IDLE, step_req = 1: latch sel, dir, and cnt; set step_busy.
    - step_sel >= NUM_CLKS: step_err pulse, stay IDLE, busy drops.
    - step_cnt = 0: step_done pulse next cycle, no phase_en.
    - Otherwise -> PULSE.
  - PULSE: phase_en = 1 for exactly PHASE_EN_CYC cycles, then -> WAIT_LO. cntsel and updn are driven from the latched values for the whole step and held after.
  - WAIT_LO: wait for synchronised phase_done = 0, then -> WAIT_HI.
  - WAIT_HI: wait for synchronised phase_done = 1. Then decrement the remaining count.
    - If the count is now 0: step_done pulse, clear busy -> IDLE.
    - Otherwise: one idle cycle, then -> PULSE.
- Timeout: a single counter is cleared on entry to WAIT_LO and runs through WAIT_LO and WAIT_HI. At STEP_TIMEOUT cycles: step_err pulse, phase_en 0, busy 0 -> IDLE.
- Lock loss in any state other than WAIT_LOCK:
  - phase_en is forced to 0 in the same cycle locked_filt falls.
  - If busy, a step_err pulse is issued and busy is cleared.
  - FSM -> WAIT_LOCK.
- step_req while busy or in WAIT_LOCK is ignored; no error is raised.
- rst mid-step returns all outputs to their reset values on the next edge.

## Timing
- pll_locked rise to locked_filt rise: LOCK_FILT+2 cycles. locked_filt to lvds_rst fall: 1 cycle.
- pll_locked fall to locked_filt fall: 3 cycles. locked_filt fall to lvds_rst rise: 1 cycle.
- step_req accepted at edge N: phase_en high from N+1 to N+PHASE_EN_CYC.
- phase_done edges are seen 2 cycles late (synchroniser).
- step_done follows, by 1 cycle, the cycle in which the final synchronised phase_done rise is seen.
- Minimum per-step period: PHASE_EN_CYC + 2 + PLL response + 2 synchroniser + 1 gap.

## Test plan
- Reset, then pll_locked = 1 at cycle 0 with LOCK_FILT = 16 -> locked_filt rises at cycle 18, lvds_rst falls at cycle 19, lock_loss_cnt = 0.
- PLL model lowers phase_done 3 cycles after each phase_en and restores it 5 cycles later; step_cnt = 3, dir = 1, sel = 2 -> three 2-cycle phase_en pulses with updn = 1 and cntsel = 2, then one step_done pulse; busy is high throughout.
- step_cnt = 0 -> step_done one cycle after acceptance, no phase_en; step_sel = 7 with NUM_CLKS = 4 -> step_err, no phase_en.
- Model never returns phase_done, STEP_TIMEOUT = 20 -> step_err exactly 20 cycles after entering WAIT_LO; FSM back in IDLE and accepts a new request.
- Drop pll_locked during WAIT_HI -> phase_en 0, step_err pulse, lvds_rst 1, lock_loss_cnt = 1; relock -> IDLE after LOCK_FILT+2 cycles.
- Toggle lock 300 times -> lock_loss_cnt saturates at 255. Assert rst mid-PULSE -> every output at its reset value on the next cycle.
